display_scan_driver: RTL and testbench

// Output stage of the calculator board: takes the 16-bit result word and a format select and drives the
// 8-digit multiplexed 7-segment display. Hex mode shows 4 nibbles; decimal mode converts with a sequential

---
 rtl/display_scan_driver_if.sv | 18 +
 rtl/display_scan_driver.sv | 140 ++++++++++++++
 tb/tb_display_scan_driver.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/display_scan_driver_if.sv
// rtl/display_scan_driver_if.sv - value/format input and segment/anode output bundle for the scan driver
interface display_scan_driver_if;
    logic [15:0] ToDisplay;
    logic        DisplayFormat;
    logic [6:0]  Segments;
    logic [7:0]  Anodes;
    logic        Busy;

    modport master (
        output ToDisplay, DisplayFormat,
        input  Segments, Anodes, Busy
    );

    modport slave (
        input  ToDisplay, DisplayFormat,
        output Segments, Anodes, Busy
    );
endinterface

// File: rtl/display_scan_driver.sv
// rtl/display_scan_driver.sv - 8-digit multiplexed 7-segment driver with hex and double-dabble decimal modes
module display_scan_driver #(
    parameter int REFRESH_DIV = 100_000
) (
    input  logic                  clk,
    input  logic                  reset,
    display_scan_driver_if.slave  bus
);

    localparam int CW = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    state_t      state;
    logic        snap_valid;
    logic [15:0] snap_val;
    logic        snap_fmt;
    logic [15:0] shift_reg;
    logic [19:0] bcd;
    logic [19:0] bcd_adj;
    logic [3:0]  iter;
    logic [19:0] digits;
    logic        dmode;
    logic        busy;

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [31:0]   digits_ext;
    logic [31:0]   upper;
    logic [3:0]    nib;
    logic          blank;

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 5; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5)
                bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            snap_valid <= 1'b0;
            snap_val   <= '0;
            snap_fmt   <= 1'b0;
            shift_reg  <= '0;
            bcd        <= '0;
            iter       <= '0;
            digits     <= '0;
            dmode      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!snap_valid || {bus.ToDisplay, bus.DisplayFormat} != {snap_val, snap_fmt}) begin
                        snap_valid <= 1'b1;
                        snap_val   <= bus.ToDisplay;
                        snap_fmt   <= bus.DisplayFormat;
                        shift_reg  <= bus.ToDisplay;
                        bcd        <= '0;
                        iter       <= '0;
                        busy       <= 1'b1;
                        state      <= bus.DisplayFormat ? CONV : COMMIT;
                    end
                end
                CONV: begin
                    {bcd, shift_reg} <= {bcd_adj, shift_reg} << 1;
                    iter <= iter + 4'd1;
                    if (iter == 4'd15)
                        state <= COMMIT;
                end
                COMMIT: begin
                    // hex mode never shifts, so shift_reg still holds the snapshot word
                    digits <= snap_fmt ? bcd : {4'h0, shift_reg};
                    dmode  <= snap_fmt;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.Busy = busy;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
    endfunction

    // a decimal slot is a leading zero when it and every higher nibble are zero
    always_comb begin
        digits_ext = {12'h000, digits};
        upper      = digits_ext >> {idx, 2'b00};
        nib        = upper[3:0];
        if (dmode)
            blank = (idx >= 3'd5) || ((idx != 3'd0) && (upper == 32'd0));
        else
            blank = (idx >= 3'd4);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            idx          <= '0;
            bus.Segments <= 7'h7F;
            bus.Anodes   <= 8'hFF;
        end else begin
            if (cnt == CW'(REFRESH_DIV - 1)) begin
                cnt <= '0;
                idx <= idx + 3'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            bus.Anodes   <= blank ? 8'hFF : ~(8'b1 << idx);
            bus.Segments <= blank ? 7'h7F : glyph(nib);
        end
    end

endmodule

// File: tb/tb_display_scan_driver.sv
// tb/tb_display_scan_driver.sv - scoreboard bench for display_scan_driver
module tb_display_scan_driver;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    display_scan_driver_if bus();

    display_scan_driver #(.REFRESH_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [14:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] tbl [16];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return tbl[d];
    endfunction

    task automatic push_frame(input logic [15:0] v, input logic fmt);
        int val;
        int p;
        logic [3:0] d;
        logic show;
        val = int'(v);
        p = 1;
        for (int i = 0; i < 8; i++) begin
            if (!fmt) begin
                d = 4'((val >> (4 * i)) & 15);
                show = (i < 4);
            end else begin
                d = 4'((val / p) % 10);
                show = (i < 5) && ((i == 0) || (val >= p));
                if (i < 5) p = p * 10;
            end
            exp_q.push_back({show ? ~(8'b1 << i) : 8'hFF, show ? seg_of(d) : 7'h7F});
        end
    endtask

    task automatic busy_burst(output int n);
        int w;
        n = 0;
        w = 0;
        @(negedge clk);
        while (bus.Busy !== 1'b1 && w < 10) begin
            @(negedge clk);
            w++;
        end
        while (bus.Busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic capture_frame(input string tag);
        int w;
        logic [14:0] e;
        w = 0;
        while (bus.Anodes === 8'hFE && w < 80) begin
            @(negedge clk);
            w++;
        end
        while (bus.Anodes !== 8'hFE && w < 80) begin
            @(negedge clk);
            w++;
        end
        if (w >= 80) begin
            check({tag, "_sync_timeout"}, 32'(w), 32'd0);
            repeat (8) void'(exp_q.pop_front());
        end else begin
            for (int i = 0; i < 8; i++) begin
                e = exp_q.pop_front();
                check($sformatf("%s_slot%0d", tag, i), {17'd0, bus.Anodes, bus.Segments}, {17'd0, e});
                repeat (4) @(negedge clk);
            end
        end
    endtask

    task automatic run_value(input string tag, input logic [15:0] v, input logic fmt, input int exp_busy);
        int n;
        push_frame(v, fmt);
        bus.ToDisplay = v;
        bus.DisplayFormat = fmt;
        busy_burst(n);
        check({tag, "_busy_len"}, 32'(n), 32'(exp_busy));
        capture_frame(tag);
    endtask

    initial begin
        int n;
        int w;
        bus.ToDisplay = 16'd0;
        bus.DisplayFormat = 1'b1;
        reset = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_anodes", {24'd0, bus.Anodes}, 32'hFF);
        check("rst_segments", {25'd0, bus.Segments}, 32'h7F);
        check("rst_busy", {31'd0, bus.Busy}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        push_frame(16'd0, 1'b1);
        busy_burst(n);
        check("t1_busy_len", 32'(n), 32'd17);
        capture_frame("t1");

        run_value("t2", 16'h1234, 1'b0, 1);
        run_value("t3", 16'd65535, 1'b1, 17);
        run_value("t4", 16'd7, 1'b1, 17);
        run_value("hexab", 16'hAB0F, 1'b0, 1);

        // change the input in the middle of a decimal conversion
        push_frame(16'd200, 1'b1);
        bus.ToDisplay = 16'd100;
        bus.DisplayFormat = 1'b1;
        @(negedge clk);
        w = 0;
        while (bus.Busy !== 1'b1 && w < 10) begin
            @(negedge clk);
            w++;
        end
        n = (bus.Busy === 1'b1) ? 1 : 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.Busy === 1'b1) n++;
        end
        bus.ToDisplay = 16'd200;
        while (bus.Busy === 1'b1 && n < 40) begin
            @(negedge clk);
            if (bus.Busy === 1'b1) n++;
        end
        check("t5_first_busy_len", 32'(n), 32'd17);
        busy_burst(n);
        check("t5_second_busy_len", 32'(n), 32'd17);
        capture_frame("t5");

        // reset in the 8th conversion cycle
        bus.ToDisplay = 16'd4321;
        @(negedge clk);
        w = 0;
        while (bus.Busy !== 1'b1 && w < 10) begin
            @(negedge clk);
            w++;
        end
        check("t6_busy_start", {31'd0, bus.Busy}, 32'd1);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t6_rst_busy", {31'd0, bus.Busy}, 32'd0);
        check("t6_rst_anodes", {24'd0, bus.Anodes}, 32'hFF);
        check("t6_rst_segments", {25'd0, bus.Segments}, 32'h7F);
        @(negedge clk);
        reset = 1'b0;
        push_frame(16'd4321, 1'b1);
        busy_burst(n);
        check("t6_busy_len", 32'(n), 32'd17);
        capture_frame("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
